alu_operand_stage: RTL and testbench

- Parametrised successor to the CPU core's ALU operand data mux.
- Selects the file operand (fout) from the special registers or the register file, with write-back forwarding from the ALU result.
- Builds the ALU A/B operands from a wider mode set, including a generalised bit decoder.
- Registers the operands into a valid/ready output stage with a one-entry skid buffer and flush. Sits between instruction decode and the ALU.

---
 rtl/alu_operand_pkg.sv | 22 ++
 rtl/alu_operand_stage_if.sv | 47 ++++
 rtl/operand_skid_buf.sv | 81 ++++++++
 rtl/alu_operand_stage.sv | 84 ++++++++
 tb/tb_alu_operand_stage.sv | 169 ++++++++++++++++
 5 files changed

// File: rtl/alu_operand_pkg.sv
// Shared definitions for the ALU operand stage: operand-mode encodings and
// output-buffer state encoding.
package alu_operand_pkg;

  localparam int unsigned OPSEL_W = 3;

  localparam logic [OPSEL_W-1:0] OPSEL_WREG  = 3'b000;
  localparam logic [OPSEL_W-1:0] OPSEL_FOUT  = 3'b001;
  localparam logic [OPSEL_W-1:0] OPSEL_K     = 3'b010;
  localparam logic [OPSEL_W-1:0] OPSEL_BD    = 3'b011;
  localparam logic [OPSEL_W-1:0] OPSEL_ONE   = 3'b100;
  localparam logic [OPSEL_W-1:0] OPSEL_ZERO  = 3'b101;
  localparam logic [OPSEL_W-1:0] OPSEL_NFOUT = 3'b110;
  localparam logic [OPSEL_W-1:0] OPSEL_RSVD  = 3'b111;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } skid_state_e;

endpackage

// File: rtl/alu_operand_stage_if.sv
// Decode-side request, write-back forwarding and ALU-side operand handshake
// of the ALU operand stage.
interface alu_operand_stage_if
  import alu_operand_pkg::*;
#(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned SPECIAL_W = 3,
  parameter int unsigned FSEL_W    = 5
);
  localparam int unsigned NUM_SPECIAL = 2 ** SPECIAL_W;
  localparam int unsigned BIT_W       = $clog2(DATA_W);

  logic                          in_valid;
  logic                          in_ready;
  logic [FSEL_W-1:0]             fsel;
  logic [NUM_SPECIAL*DATA_W-1:0] special_in;
  logic [DATA_W-1:0]             regfile_out;
  logic [DATA_W-1:0]             w;
  logic [DATA_W-1:0]             k;
  logic [OPSEL_W-1:0]            alua_sel;
  logic [OPSEL_W-1:0]            alub_sel;
  logic [BIT_W-1:0]              bit_sel;
  logic                          bdpol;
  logic                          wb_valid;
  logic [FSEL_W-1:0]             wb_fsel;
  logic [DATA_W-1:0]             aluout;
  logic [DATA_W-1:0]             fin;
  logic                          flush;
  logic                          out_valid;
  logic                          out_ready;
  logic [DATA_W-1:0]             alua;
  logic [DATA_W-1:0]             alub;
  logic                          fwd_hit;

  modport slave (
    input  in_valid, fsel, special_in, regfile_out, w, k, alua_sel, alub_sel, bit_sel, bdpol,
           wb_valid, wb_fsel, aluout, flush, out_ready,
    output in_ready, fin, out_valid, alua, alub, fwd_hit
  );

  modport master (
    output in_valid, fsel, special_in, regfile_out, w, k, alua_sel, alub_sel, bit_sel, bdpol,
           wb_valid, wb_fsel, aluout, flush, out_ready,
    input  in_ready, fin, out_valid, alua, alub, fwd_hit
  );

endinterface

// File: rtl/operand_skid_buf.sv
// Two-entry valid/ready buffer (output register plus one skid slot) with a
// flush that empties both entries.
module operand_skid_buf
  import alu_operand_pkg::*;
#(
  parameter int unsigned WIDTH = 17
) (
  input  logic             clk2,
  input  logic             resetn,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o
);

  skid_state_e      state_q, state_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             accept;
  logic             drain;

  assign in_ready_o  = (state_q != ST_TWO);
  assign out_valid_o = (state_q != ST_EMPTY);
  assign out_data_o  = out_q;
  assign accept      = in_valid_i && in_ready_o;
  assign drain       = out_valid_o && out_ready_i;

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    skid_d  = skid_q;
    if (flush_i) begin
      // Same-cycle accept is dropped; the output register is left as is since
      // out_valid is low until the next accept reloads it.
      state_d = ST_EMPTY;
      skid_d  = '0;
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            out_d   = in_data_i;
            state_d = ST_ONE;
          end
        end
        ST_ONE: begin
          if (accept && drain) begin
            out_d = in_data_i;
          end else if (accept) begin
            skid_d  = in_data_i;
            state_d = ST_TWO;
          end else if (drain) begin
            state_d = ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (drain) begin
            out_d   = skid_q;
            state_d = ST_ONE;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk2 or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_EMPTY;
      out_q   <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      skid_q  <= skid_d;
    end
  end

endmodule

// File: rtl/alu_operand_stage.sv
// ALU operand stage: file-operand select with write-back forwarding, A/B
// operand mode muxes, and a registered valid/ready output with skid buffer.
module alu_operand_stage
  import alu_operand_pkg::*;
#(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned SPECIAL_W = 3,
  parameter int unsigned FSEL_W    = 5
) (
  input  logic                clk2,
  input  logic                resetn,
  alu_operand_stage_if.slave  bus
);

  localparam int unsigned NUM_SPECIAL = 2 ** SPECIAL_W;
  localparam int unsigned PAYLOAD_W   = 2 * DATA_W + 1;
  localparam logic [DATA_W-1:0] ONE_C = {{(DATA_W-1){1'b0}}, 1'b1};

  logic [NUM_SPECIAL-1:0][DATA_W-1:0] special_arr;
  logic [DATA_W-1:0]                  fout;
  logic [DATA_W-1:0]                  bd;
  logic                               fwd;
  logic [PAYLOAD_W-1:0]               in_data;
  logic [PAYLOAD_W-1:0]               out_data;

  assign special_arr = bus.special_in;
  assign bus.fin     = bus.aluout;

  always_comb begin
    fwd = bus.wb_valid && (bus.wb_fsel == bus.fsel);
    if (fwd) begin
      fout = bus.aluout;
    end else if (bus.fsel[FSEL_W-1:SPECIAL_W] != '0) begin
      fout = bus.regfile_out;
    end else begin
      fout = special_arr[bus.fsel[SPECIAL_W-1:0]];
    end
  end

  assign bd = (ONE_C << bus.bit_sel) ^ {DATA_W{bus.bdpol}};

  function automatic logic [DATA_W-1:0] pick_operand(input logic [OPSEL_W-1:0] sel,
                                                     input logic [DATA_W-1:0]  w_val,
                                                     input logic [DATA_W-1:0]  k_val,
                                                     input logic [DATA_W-1:0]  fout_val,
                                                     input logic [DATA_W-1:0]  bd_val);
    logic [DATA_W-1:0] res;
    unique case (sel)
      OPSEL_WREG:  res = w_val;
      OPSEL_FOUT:  res = fout_val;
      OPSEL_K:     res = k_val;
      OPSEL_BD:    res = bd_val;
      OPSEL_ONE:   res = ONE_C;
      OPSEL_ZERO:  res = '0;
      OPSEL_NFOUT: res = ~fout_val;
      OPSEL_RSVD:  res = '0;
      default:     res = '0;
    endcase
    return res;
  endfunction

  assign in_data = {fwd,
                    pick_operand(bus.alua_sel, bus.w, bus.k, fout, bd),
                    pick_operand(bus.alub_sel, bus.w, bus.k, fout, bd)};

  operand_skid_buf #(
    .WIDTH (PAYLOAD_W)
  ) u_skid (
    .clk2        (clk2),
    .resetn      (resetn),
    .flush_i     (bus.flush),
    .in_valid_i  (bus.in_valid),
    .in_ready_o  (bus.in_ready),
    .in_data_i   (in_data),
    .out_valid_o (bus.out_valid),
    .out_ready_i (bus.out_ready),
    .out_data_o  (out_data)
  );

  assign bus.fwd_hit = out_data[2*DATA_W];
  assign bus.alua    = out_data[2*DATA_W-1:DATA_W];
  assign bus.alub    = out_data[DATA_W-1:0];

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed bench for alu_operand_stage at DATA_W=8 and DATA_W=32.
module tb_alu_operand_stage;

  logic clk2   = 1'b0;
  logic resetn = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk2 = ~clk2;

  alu_operand_stage_if #(.DATA_W(8), .SPECIAL_W(3), .FSEL_W(5)) b8 ();
  alu_operand_stage_if #(.DATA_W(32), .SPECIAL_W(3), .FSEL_W(5)) b32 ();

  alu_operand_stage #(.DATA_W(8), .SPECIAL_W(3), .FSEL_W(5)) u_dut8 (
    .clk2   (clk2),
    .resetn (resetn),
    .bus    (b8)
  );

  alu_operand_stage #(.DATA_W(32), .SPECIAL_W(3), .FSEL_W(5)) u_dut32 (
    .clk2   (clk2),
    .resetn (resetn),
    .bus    (b32)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk2);
    #1;
  endtask

  task automatic init_bus8();
    b8.in_valid = 0; b8.fsel = '0; b8.special_in = '0; b8.regfile_out = '0;
    b8.w = '0; b8.k = '0; b8.alua_sel = '0; b8.alub_sel = '0; b8.bit_sel = '0;
    b8.bdpol = 0; b8.wb_valid = 0; b8.wb_fsel = '0; b8.aluout = '0; b8.flush = 0;
    b8.out_ready = 1;
    b32.in_valid = 0; b32.fsel = '0; b32.special_in = '0; b32.regfile_out = '0;
    b32.w = '0; b32.k = '0; b32.alua_sel = '0; b32.alub_sel = '0; b32.bit_sel = '0;
    b32.bdpol = 0; b32.wb_valid = 0; b32.wb_fsel = '0; b32.aluout = '0; b32.flush = 0;
    b32.out_ready = 1;
  endtask

  initial begin
    init_bus8();
    b8.special_in[2*8 +: 8] = 8'hA5;
    #2;
    check("rst_out_valid", 32'(b8.out_valid), 32'h0);
    check("rst_in_ready", 32'(b8.in_ready), 32'h1);
    check("rst_alua", 32'(b8.alua), 32'h0);
    check("rst_alub", 32'(b8.alub), 32'h0);
    check("rst_fwd_hit", 32'(b8.fwd_hit), 32'h0);
    @(negedge clk2);
    resetn = 1;

    // Special register read
    b8.fsel = 5'h02; b8.alua_sel = 3'b001; b8.alub_sel = 3'b100; b8.in_valid = 1;
    step();
    check("spec_out_valid", 32'(b8.out_valid), 32'h1);
    check("spec_alua", 32'(b8.alua), 32'hA5);
    check("spec_alub", 32'(b8.alub), 32'h01);
    check("spec_fwd", 32'(b8.fwd_hit), 32'h0);

    // Forwarding hit, then miss to regfile
    b8.fsel = 5'h10; b8.regfile_out = 8'h11; b8.wb_valid = 1; b8.wb_fsel = 5'h10;
    b8.aluout = 8'h3C; b8.alub_sel = 3'b101;
    #1;
    check("fin_pass", 32'(b8.fin), 32'h3C);
    step();
    check("fwd_alua", 32'(b8.alua), 32'h3C);
    check("fwd_hit", 32'(b8.fwd_hit), 32'h1);
    check("fwd_alub_zero", 32'(b8.alub), 32'h0);
    b8.wb_fsel = 5'h11;
    step();
    check("nofwd_alua", 32'(b8.alua), 32'h11);
    check("nofwd_hit", 32'(b8.fwd_hit), 32'h0);
    b8.wb_valid = 0;

    // Bit decoder and remaining modes
    b8.alua_sel = 3'b011; b8.bit_sel = 3'd5; b8.bdpol = 0;
    step();
    check("bd_pol0", 32'(b8.alua), 32'h20);
    b8.bdpol = 1;
    step();
    check("bd_pol1", 32'(b8.alua), 32'hDF);
    b8.fsel = 5'h08; b8.regfile_out = 8'h0F; b8.alub_sel = 3'b110;
    b8.alua_sel = 3'b000; b8.w = 8'h5A;
    step();
    check("nfout_alub", 32'(b8.alub), 32'hF0);
    check("w_alua", 32'(b8.alua), 32'h5A);
    b8.alub_sel = 3'b111; b8.alua_sel = 3'b010; b8.k = 8'h77;
    step();
    check("rsvd_alub", 32'(b8.alub), 32'h00);
    check("k_alua", 32'(b8.alua), 32'h77);
    b8.in_valid = 0;
    step();
    check("drain_empty", 32'(b8.out_valid), 32'h0);

    // Backpressure: two held, third stalled until space frees
    b8.out_ready = 0; b8.alua_sel = 3'b010; b8.in_valid = 1; b8.k = 8'd1;
    step();
    b8.k = 8'd2;
    step();
    check("bp_in_ready_full", 32'(b8.in_ready), 32'h0);
    check("bp_first", 32'(b8.alua), 32'd1);
    b8.k = 8'd3;
    step();
    check("bp_hold", 32'(b8.alua), 32'd1);
    check("bp_hold_valid", 32'(b8.out_valid), 32'h1);
    b8.out_ready = 1;
    step();
    check("bp_second", 32'(b8.alua), 32'd2);
    check("bp_in_ready_free", 32'(b8.in_ready), 32'h1);
    step();
    check("bp_third", 32'(b8.alua), 32'd3);
    b8.in_valid = 0;
    step();
    check("bp_no_dup", 32'(b8.out_valid), 32'h0);

    // Flush from TWO with a same-cycle request
    b8.out_ready = 0; b8.in_valid = 1; b8.k = 8'd4;
    step();
    b8.k = 8'd5;
    step();
    b8.flush = 1; b8.k = 8'd6;
    step();
    check("flush_valid", 32'(b8.out_valid), 32'h0);
    check("flush_ready", 32'(b8.in_ready), 32'h1);
    b8.flush = 0; b8.in_valid = 0; b8.out_ready = 1;
    step();
    check("flush_nothing", 32'(b8.out_valid), 32'h0);
    b8.in_valid = 1; b8.k = 8'd7;
    step();
    check("post_flush", 32'(b8.alua), 32'd7);

    // Reset mid-operation loses buffered operands
    b8.out_ready = 0; b8.k = 8'd8;
    step();
    b8.in_valid = 0;
    resetn = 0;
    #1;
    check("midrst_valid", 32'(b8.out_valid), 32'h0);
    check("midrst_alua", 32'(b8.alua), 32'h0);
    resetn = 1;
    step();
    check("midrst_stays_empty", 32'(b8.out_valid), 32'h0);
    b8.out_ready = 1;

    // Width scaling
    b32.alua_sel = 3'b011; b32.bit_sel = 5'd31; b32.bdpol = 0;
    b32.alub_sel = 3'b100; b32.in_valid = 1;
    step();
    check("w32_bd31", b32.alua, 32'h8000_0000);
    check("w32_one", b32.alub, 32'h0000_0001);
    check("w32_valid", 32'(b32.out_valid), 32'h1);
    b32.in_valid = 0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
